// File: rtl/dt_res_pack.sv
// Packs the 8-bit result map back into 16-pixel binary words (MSB = lowest pixel
// address). A pixel is set when the byte meets the threshold, or misses it when INVERT is set.
module dt_res_pack #(
   parameter int PIX_AW = 14,
   parameter bit INVERT = 1'b0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [7:0]        threshold,
   output logic              done,
   output logic              res_rd,
   output logic [PIX_AW-1:0] res_addr,
   input  logic [7:0]        res_di,
   output logic              pk_wr,
   output logic [PIX_AW-5:0] pk_addr,
   output logic [15:0]       pk_do
);

   localparam int WAW = PIX_AW - 4;
   localparam logic [PIX_AW-1:0] ADDR_LAST_M1 = {{(PIX_AW-1){1'b1}}, 1'b0};

   typedef enum logic [2:0] {S_IDLE, S_READ, S_DRAIN, S_FIN, S_DONE} state_t;

   state_t            state_q, state_d;
   logic              done_q, done_d;
   logic              res_rd_q, res_rd_d;
   logic [PIX_AW-1:0] res_addr_q, res_addr_d;
   logic              pk_wr_q, pk_wr_d;
   logic [WAW-1:0]    pk_addr_q, pk_addr_d;
   logic [15:0]       pk_do_q, pk_do_d;
   logic [15:0]       shreg_q, shreg_d;
   logic [3:0]        bit_cnt_q, bit_cnt_d;
   logic              pix_bit;

   always_comb begin
      state_d    = state_q;
      done_d     = done_q;
      res_rd_d   = res_rd_q;
      res_addr_d = res_addr_q;
      pk_wr_d    = 1'b0;
      pk_addr_d  = pk_addr_q;
      pk_do_d    = pk_do_q;
      shreg_d    = shreg_q;
      bit_cnt_d  = bit_cnt_q;
      pix_bit    = INVERT ? (res_di < threshold) : (res_di >= threshold);

      // res_di seen this cycle belongs to the address issued on the previous edge
      if (res_rd_q) begin
         shreg_d   = {shreg_q[14:0], pix_bit};
         bit_cnt_d = bit_cnt_q + 4'd1;
         if (bit_cnt_q == 4'hF) begin
            pk_wr_d   = 1'b1;
            pk_do_d   = shreg_d;
            pk_addr_d = res_addr_q[PIX_AW-1:4];
         end
      end

      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d    = S_READ;
               done_d     = 1'b0;
               res_rd_d   = 1'b1;
               res_addr_d = '0;
               bit_cnt_d  = '0;
            end
         end
         S_READ: begin
            res_addr_d = res_addr_q + PIX_AW'(1);
            if (res_addr_q == ADDR_LAST_M1) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            res_rd_d = 1'b0;
            state_d  = S_FIN;
         end
         S_FIN: begin
            done_d  = 1'b1;
            state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         done_q     <= 1'b0;
         res_rd_q   <= 1'b0;
         res_addr_q <= '0;
         pk_wr_q    <= 1'b0;
         pk_addr_q  <= '0;
         pk_do_q    <= '0;
         shreg_q    <= '0;
         bit_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         done_q     <= done_d;
         res_rd_q   <= res_rd_d;
         res_addr_q <= res_addr_d;
         pk_wr_q    <= pk_wr_d;
         pk_addr_q  <= pk_addr_d;
         pk_do_q    <= pk_do_d;
         shreg_q    <= shreg_d;
         bit_cnt_q  <= bit_cnt_d;
      end
   end

   assign done     = done_q;
   assign res_rd   = res_rd_q;
   assign res_addr = res_addr_q;
   assign pk_wr    = pk_wr_q;
   assign pk_addr  = pk_addr_q;
   assign pk_do    = pk_do_q;

endmodule

// File: tb/tb_dt_res_pack.sv
// Bench for dt_res_pack: a 1024-pixel map (PIX_AW=10) keeps every pass short; one
// instance per INVERT setting shares the stimulus and a combinational-read res memory.
module tb_dt_res_pack;

   localparam int PA  = 10;
   localparam int WAW = PA - 4;
   localparam int NP  = 1 << PA;
   localparam int NW  = 1 << WAW;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [7:0]    threshold;
   logic          done0, done1, res_rd0, res_rd1, pk_wr0, pk_wr1;
   logic [PA-1:0] res_addr0, res_addr1;
   logic [7:0]    res_di0, res_di1;
   logic [WAW-1:0] pk_addr0, pk_addr1;
   logic [15:0]   pk_do0, pk_do1;

   logic [7:0]    mem [NP];
   logic          cur_inv;
   logic          done_s, res_rd_s, pk_wr_s;
   logic [PA-1:0] res_addr_s;
   logic [WAW-1:0] pk_addr_s;
   logic [15:0]   pk_do_s;

   int n_pass = 0;
   int n_tot  = 0;

   always #5 clk = ~clk;

   assign res_di0 = mem[res_addr0];
   assign res_di1 = mem[res_addr1];

   dt_res_pack #(.PIX_AW(PA), .INVERT(1'b0)) u_dut0 (
      .clk(clk), .reset(reset), .start(start), .threshold(threshold),
      .done(done0), .res_rd(res_rd0), .res_addr(res_addr0), .res_di(res_di0),
      .pk_wr(pk_wr0), .pk_addr(pk_addr0), .pk_do(pk_do0));

   dt_res_pack #(.PIX_AW(PA), .INVERT(1'b1)) u_dut1 (
      .clk(clk), .reset(reset), .start(start), .threshold(threshold),
      .done(done1), .res_rd(res_rd1), .res_addr(res_addr1), .res_di(res_di1),
      .pk_wr(pk_wr1), .pk_addr(pk_addr1), .pk_do(pk_do1));

   always_comb begin
      done_s     = cur_inv ? done1     : done0;
      res_rd_s   = cur_inv ? res_rd1   : res_rd0;
      res_addr_s = cur_inv ? res_addr1 : res_addr0;
      pk_wr_s    = cur_inv ? pk_wr1    : pk_wr0;
      pk_addr_s  = cur_inv ? pk_addr1  : pk_addr0;
      pk_do_s    = cur_inv ? pk_do1    : pk_do0;
   end

   // a0/a1 < 0 means no override; w0 = word 0, wl = last word, wo = every other word
   typedef struct {
      logic [7:0]  fill;
      int          a0;
      logic [7:0]  v0;
      int          a1;
      logic [7:0]  v1;
      logic [7:0]  thr;
      logic        inv;
      logic [15:0] w0;
      logic [15:0] wl;
      logic [15:0] wo;
   } vec_t;

   vec_t vecs [8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic load_mem(input vec_t v);
      for (int i = 0; i < NP; i++) mem[i] = v.fill;
      if (v.a0 >= 0) mem[v.a0] = v.v0;
      if (v.a1 >= 0) mem[v.a1] = v.v1;
   endtask

   task automatic run_pass(input int vi, input int pulse_at, input string tag);
      vec_t v;
      int wcnt, oerr, bad, extra;
      logic d_pre, d_at;
      logic [15:0] words [NW];
      v = vecs[vi];
      load_mem(v);
      threshold = v.thr;
      cur_inv   = v.inv;
      @(negedge clk) start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      chk({tag, " done_clr"}, 32'(done_s), 32'd0);
      chk({tag, " rd_first"}, {31'd0, res_rd_s} | (32'(res_addr_s) << 1), 32'd1);
      wcnt = 0; oerr = 0; d_pre = 1'bx; d_at = 1'bx;
      for (int e = 1; e <= NP + 1; e++) begin
         if (e == pulse_at) start = 1'b1;
         @(posedge clk);
         #1 start = 1'b0;
         if (pk_wr_s) begin
            if (32'(pk_addr_s) != wcnt) oerr++;
            if (wcnt < NW) words[wcnt] = pk_do_s;
            wcnt++;
         end
         if (e == NP)     d_pre = done_s;
         if (e == NP + 1) d_at  = done_s;
      end
      chk({tag, " wr_count"}, 32'(wcnt), 32'(NW));
      chk({tag, " addr_order"}, 32'(oerr), 32'd0);
      chk({tag, " done_early"}, 32'(d_pre), 32'd0);
      chk({tag, " done_rise"}, 32'(d_at), 32'd1);
      chk({tag, " word_first"}, 32'(words[0]), 32'(v.w0));
      chk({tag, " word_last"}, 32'(words[NW-1]), 32'(v.wl));
      bad = 0;
      for (int k = 1; k < NW - 1; k++) if (words[k] !== v.wo) bad++;
      chk({tag, " word_mid"}, 32'(bad), 32'd0);
      extra = 0;
      repeat (5) begin
         @(posedge clk);
         #1 if (pk_wr_s || !done_s) extra++;
      end
      chk({tag, " done_hold"}, 32'(extra), 32'd0);
   endtask

   initial begin
      vecs[0] = '{8'h00, -1, 8'h00, -1, 8'h00, 8'h01, 1'b0, 16'h0000, 16'h0000, 16'h0000};
      vecs[1] = '{8'h00,  0, 8'h05, -1, 8'h00, 8'h05, 1'b0, 16'h8000, 16'h0000, 16'h0000};
      vecs[2] = '{8'h00,  0, 8'h05, -1, 8'h00, 8'h06, 1'b0, 16'h0000, 16'h0000, 16'h0000};
      vecs[3] = '{8'h00, 15, 8'h01, NP-1, 8'hC8, 8'h01, 1'b0, 16'h0001, 16'h0001, 16'h0000};
      vecs[4] = '{8'hFF, -1, 8'h00, -1, 8'h00, 8'h80, 1'b1, 16'h0000, 16'h0000, 16'h0000};
      vecs[5] = '{8'hFF, -1, 8'h00, -1, 8'h00, 8'h80, 1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFF};
      vecs[6] = '{8'h00,  0, 8'h80, -1, 8'h00, 8'h80, 1'b1, 16'h7FFF, 16'hFFFF, 16'hFFFF};
      vecs[7] = '{8'h7F, -1, 8'h00, NP-1, 8'h80, 8'h80, 1'b0, 16'h0000, 16'h0001, 16'h0000};

      reset = 1'b0; start = 1'b0; threshold = 8'h00; cur_inv = 1'b0;
      load_mem(vecs[0]);
      #12;
      chk("rst_ctl0", {29'd0, done0, res_rd0, pk_wr0}, 32'd0);
      chk("rst_addr0", 32'(res_addr0) | 32'(pk_addr0), 32'd0);
      chk("rst_do0", 32'(pk_do0), 32'd0);
      chk("rst_ctl1", {29'd0, done1, res_rd1, pk_wr1}, 32'd0);
      @(negedge clk) reset = 1'b1;
      repeat (3) @(posedge clk);
      #1 chk("idle_quiet", {30'd0, done0, res_rd0}, 32'd0);

      for (int vi = 0; vi < 8; vi++) run_pass(vi, 0, $sformatf("vec%0d", vi));

      // start mid-pass must be ignored; start again from DONE runs a fresh pass
      run_pass(3, 500, "restart_ign");
      run_pass(3, 0, "second_pass");

      begin
         int cnt;
         load_mem(vecs[3]);
         threshold = 8'h01; cur_inv = 1'b0;
         @(negedge clk) start = 1'b1;
         @(posedge clk);
         #1 start = 1'b0;
         repeat (600) @(posedge clk);
         #2 reset = 1'b0;
         #1;
         chk("rst_mid_ctl", {29'd0, done0, res_rd0, pk_wr0}, 32'd0);
         chk("rst_mid_addr", 32'(res_addr0) | 32'(pk_addr0), 32'd0);
         chk("rst_mid_do", 32'(pk_do0), 32'd0);
         repeat (3) @(negedge clk);
         reset = 1'b1;
         cnt = 0;
         repeat (40) begin
            @(posedge clk);
            #1 if (pk_wr0 || done0 || res_rd0) cnt++;
         end
         chk("rst_mid_quiet", 32'(cnt), 32'd0);
      end
      run_pass(1, 0, "after_rst");

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
